// File: rtl/counter_event_monitor.sv
// Watches the counter output for wrap and threshold-crossing events and
// queues each one, timestamped, in a small FIFO drained over valid/ready.
module counter_event_monitor #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned STAMP_W = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [31:0]                q_in,
  input  logic                       q_valid,
  input  logic                       arm,
  input  logic [31:0]                thresh_hi,
  input  logic [31:0]                thresh_lo,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [1:0]                 evt_code,
  output logic [31:0]                evt_value,
  output logic [STAMP_W-1:0]         evt_stamp,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       ovf,
  output logic                       collide,
  input  logic                       flag_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, PRIME, MONITOR} state_e;

  typedef struct packed {
    logic [1:0]         code;
    logic [31:0]        value;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

  state_e             state_q, state_d;
  logic [31:0]        q_prev_q, q_prev_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d, collide_q, collide_d;
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];

  logic       sample_en, push, pop, wr_en, full, empty, multi;
  logic [3:0] hit;
  logic [1:0] code;
  entry_t     head;

  always_comb begin
    sample_en = (state_q == MONITOR) && arm && q_valid;
    hit[0]    = (q_prev_q == '1) && (q_in == '0);
    hit[1]    = (q_prev_q == '0) && (q_in == '1);
    hit[2]    = (q_prev_q < thresh_hi) && (q_in >= thresh_hi);
    hit[3]    = (q_prev_q > thresh_lo) && (q_in <= thresh_lo);
    multi     = (hit & (hit - 4'd1)) != '0;
    if (hit[0])      code = 2'd0;
    else if (hit[1]) code = 2'd1;
    else if (hit[2]) code = 2'd2;
    else             code = 2'd3;
    push  = sample_en && (hit != '0);
    empty = (level_q == '0);
    full  = (level_q == LW'(DEPTH));
    pop   = !empty && evt_ready;
    // When full, a concurrent pop frees the slot the write lands in.
    wr_en = push && (!full || pop);
  end

  always_comb begin
    state_d  = state_q;
    q_prev_d = q_prev_q;
    case (state_q)
      IDLE: if (arm) state_d = PRIME;
      PRIME: begin
        if (!arm) state_d = IDLE;
        else if (q_valid) begin
          state_d  = MONITOR;
          q_prev_d = q_in;
        end
      end
      MONITOR: begin
        if (!arm) state_d = IDLE;
        else if (q_valid) q_prev_d = q_in;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stamp_d  = stamp_q + 1'b1;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(wr_en) - LW'(pop);
    mem_d    = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = '{code: code, value: q_in, stamp: stamp_q};
    if (push && full && !pop) ovf_d = 1'b1;
    else if (flag_clr)        ovf_d = 1'b0;
    else                      ovf_d = ovf_q;
    if (sample_en && multi)   collide_d = 1'b1;
    else if (flag_clr)        collide_d = 1'b0;
    else                      collide_d = collide_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      q_prev_q  <= '0;
      stamp_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_prev_q  <= q_prev_d;
      stamp_q   <= stamp_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      collide_q <= collide_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    evt_valid  = !empty;
    evt_code   = empty ? '0 : head.code;
    evt_value  = empty ? '0 : head.value;
    evt_stamp  = empty ? '0 : head.stamp;
    fifo_level = level_q;
    ovf        = ovf_q;
    collide    = collide_q;
  end

endmodule

// File: tb/tb_counter_event_monitor.sv
// Scoreboard bench for counter_event_monitor: expected entries are queued as
// samples are driven and compared in order as the FIFO pops them.
module tb_counter_event_monitor;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned STAMP_W = 16;

  localparam logic [1:0] WU = 2'd0, WD = 2'd1, HI = 2'd2, LO = 2'd3;

  logic               clk = 1'b0;
  logic               resetn, q_valid, arm, evt_valid, evt_ready, ovf, collide, flag_clr;
  logic [31:0]        q_in, thresh_hi, thresh_lo, evt_value;
  logic [1:0]         evt_code;
  logic [STAMP_W-1:0] evt_stamp;
  logic [$clog2(DEPTH):0] fifo_level;

  typedef struct {
    logic [1:0]         code;
    logic [31:0]        value;
    logic [STAMP_W-1:0] stamp;
  } exp_t;

  exp_t               sb[$];
  logic [STAMP_W-1:0] stamp_m;
  int                 n_chk = 0;
  int                 n_bad = 0;

  counter_event_monitor #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .clk(clk), .resetn(resetn), .q_in(q_in), .q_valid(q_valid), .arm(arm),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_code(evt_code), .evt_value(evt_value),
    .evt_stamp(evt_stamp), .fifo_level(fifo_level), .ovf(ovf),
    .collide(collide), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: compare any pop against the scoreboard, then advance.
  task automatic tick();
    exp_t e;
    if (evt_valid && evt_ready) begin
      chk("pop_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("evt_code", 64'(evt_code), 64'(e.code));
        chk("evt_value", 64'(evt_value), 64'(e.value));
        chk("evt_stamp", 64'(evt_stamp), 64'(e.stamp));
      end
    end
    @(posedge clk);
    stamp_m = resetn ? stamp_m + 1'b1 : '0;
    @(negedge clk);
    flag_clr = 1'b0;
  endtask

  task automatic smp(input logic [31:0] v, input bit ev, input logic [1:0] code);
    exp_t e;
    q_in    = v;
    q_valid = 1'b1;
    if (ev) begin
      e.code = code; e.value = v; e.stamp = stamp_m;
      sb.push_back(e);
    end
    tick();
    q_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    evt_ready = 1'b1;
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_evt_valid", 64'(evt_valid), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 64'(evt_valid), 64'd0);
    chk({tag, "_level"}, 64'(fifo_level), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    chk({tag, "_collide"}, 64'(collide), 64'd0);
    chk({tag, "_code"}, 64'(evt_code), 64'd0);
    chk({tag, "_value"}, 64'(evt_value), 64'd0);
    chk({tag, "_stamp"}, 64'(evt_stamp), 64'd0);
  endtask

  initial begin
    resetn = 1'b0; q_in = '0; q_valid = 1'b0; arm = 1'b0; evt_ready = 1'b1;
    flag_clr = 1'b0; thresh_hi = 32'd100; thresh_lo = 32'd10; stamp_m = '0;
    @(negedge clk);
    tick(); tick();
    chk_reset_state("rst");
    resetn = 1'b1;

    // Ramp across the high threshold; priming sample must not fire.
    arm = 1'b1;
    tick();
    smp(32'd95, 0, HI);
    for (int v = 96; v <= 99; v++) smp(32'(v), 0, HI);
    smp(32'd100, 1, HI);
    chk("latency_valid", 64'(evt_valid), 64'd1);
    for (int v = 101; v <= 105; v++) smp(32'(v), 0, HI);
    drain(8);

    // Wrap-up (also crosses thresh_lo=10, so collide is raised).
    smp(32'hFFFF_FFFE, 0, WU);
    smp(32'hFFFF_FFFF, 0, WU);
    smp(32'h0, 1, WU);
    chk("wrap_up_collide", 64'(collide), 64'd1);
    flag_clr = 1'b1;
    tick();
    chk("collide_clr", 64'(collide), 64'd0);
    smp(32'd1, 0, WU);
    smp(32'd0, 0, WU);
    smp(32'hFFFF_FFFF, 1, WD);
    chk("wrap_dn_collide", 64'(collide), 64'd1);
    flag_clr = 1'b1;
    tick();
    drain(8);

    // thresh_lo=0: clean LO_CROSS, then set-over-clear priority, then wrap collision.
    thresh_lo = 32'd0;
    smp(32'd1, 0, LO);
    smp(32'd0, 1, LO);
    chk("lo_only_collide", 64'(collide), 64'd0);
    flag_clr = 1'b1;
    smp(32'hFFFF_FFFF, 1, WD);
    chk("set_beats_clr", 64'(collide), 64'd1);
    flag_clr = 1'b1;
    tick();
    smp(32'd0, 1, WU);
    chk("wrap_lo_collide", 64'(collide), 64'd1);
    flag_clr = 1'b1;
    tick();
    chk("collide_clr2", 64'(collide), 64'd0);
    drain(8);

    // Overflow: 10 events into an 8-deep FIFO with no consumer.
    thresh_lo = 32'd10;
    evt_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      smp((i % 2 == 0) ? 32'd200 : 32'd0, (i < 8), (i % 2 == 0) ? HI : LO);
    chk("full_level", 64'(fifo_level), 64'(DEPTH));
    chk("ovf_set", 64'(ovf), 64'd1);
    evt_ready = 1'b1;
    smp(32'd200, 1, HI);
    chk("full_pushpop_level", 64'(fifo_level), 64'(DEPTH));
    chk("ovf_sticky", 64'(ovf), 64'd1);
    drain(12);
    flag_clr = 1'b1;
    tick();
    chk("ovf_clr", 64'(ovf), 64'd0);

    // Disarm with a low q_prev, re-arm at 500: no stale HI_CROSS.
    smp(32'd50, 0, HI);
    arm = 1'b0;
    tick();
    arm = 1'b1;
    smp(32'd500, 0, HI);
    smp(32'd500, 0, HI);
    chk("rearm_no_event", 64'(evt_valid), 64'd0);
    smp(32'd5, 1, LO);
    drain(8);

    // Mid-operation reset with 5 entries queued.
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      smp((i % 2 == 0) ? 32'd200 : 32'd0, 1, (i % 2 == 0) ? HI : LO);
    chk("queued_level", 64'(fifo_level), 64'd5);
    resetn = 1'b0;
    tick();
    sb.delete();
    resetn = 1'b1;
    chk_reset_state("midrst");
    evt_ready = 1'b1;
    smp(32'd7, 0, HI);
    smp(32'd7, 0, HI);
    smp(32'd200, 1, HI);
    drain(8);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
